// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle zero-fill shifter, applies up to 3 positions per clock to a latched operand.
// Latency: resp_valid rises ceil(req_amt/3) edges after the accept edge (immediately after it when req_amt == 0).
// Backpressure: requests accepted only in IDLE; the result is held in DONE until resp_ready is seen high.
// Optional build macro SHIFT_SEQ_ROTATE_EN adds req_rot, selecting rotate instead of zero-fill per operation.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_dir,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             req_rot,
`endif
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [AMT_W-1:0] rem_q,   rem_d;
    logic             dir_q,   dir_d;
    logic             rot_now;

    logic [AMT_W+1:0] rem_ext;
    logic [1:0]       step;
    logic [AMT_W-1:0] rem_next;
    logic [WIDTH-1:0] shifted;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_q, rot_d;
    assign rot_now = rot_q;
`else
    assign rot_now = 1'b0;
`endif

    // Outputs decode straight from registered state so nothing on req_* reaches resp_*.
    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = data_q;

    // One sequencing step: step = min(rem, 3), applied as up to three single-bit moves.
    // Extending rem by two bits keeps the compare against 3 valid even for tiny AMT_W.
    always_comb begin
        rem_ext  = {2'b00, rem_q};
        step     = (rem_ext > (AMT_W+2)'(3)) ? 2'd3 : rem_ext[1:0];
        rem_next = rem_q - AMT_W'(step);
        shifted  = data_q;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(step)) begin
                if (dir_q) begin
                    shifted = {(rot_now ? shifted[0] : 1'b0), shifted[WIDTH-1:1]};
                end else begin
                    shifted = {shifted[WIDTH-2:0], (rot_now ? shifted[WIDTH-1] : 1'b0)};
                end
            end
        end
    end

    // Next-state logic: latch in IDLE, step in SHIFT, hold the result in DONE until taken.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    data_d  = req_data;
                    rem_d   = req_amt;
                    dir_d   = req_dir;
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot_d   = req_rot;
`endif
                    state_d = (req_amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

`ifdef SHIFT_SEQ_ROTATE_EN
    // Rotate-mode flag, captured alongside the operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end
`endif

endmodule
